pp_dma_engine: RTL

- Word-copy DMA master that consumes the SDAddr/SDCounts/DestAddr/DMAEN configuration registers exported by the peripheral block.
- On a start command it reads N words from the source region and writes them to the destination region over a single req/ack memory master port, one beat at a time.
- Reports busy/done status and a one-cycle completion interrupt back to the core.

---
 rtl/pp_dma_engine_pkg.sv | 12 +
 rtl/pp_dma_engine.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pp_dma_engine_pkg.sv
// pp_dma_engine_pkg: state encoding and shared constants for the word-copy DMA engine.
package pp_dma_engine_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        FIN  = 3'd3,
        DONE = 3'd4
    } state_e;
    localparam int DMA_EN_BIT    = 0;
    localparam int ADDR_STEP_DEF = 4;
endpackage

// File: rtl/pp_dma_engine.sv
// pp_dma_engine: single-port DMA master copying N words from a source to a destination region.
module pp_dma_engine
    import pp_dma_engine_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter int ADDR_STEP = ADDR_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] sd_addr,
    input  logic [31:0]       sd_counts,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [31:0]       dma_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              irq
);
    state_e            state_q, state_d;
    logic              en_prev_q;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [31:0]       data_q, data_d, mem_wdata_q, mem_wdata_d;
    logic              abort_q, abort_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic              busy_q, busy_d, done_q, done_d, aborted_q, aborted_d, irq_q, irq_d;
    logic              en, rise, fall;
    logic [CNT_W-1:0]  n_words;
    logic              unused_cfg;

    assign en         = dma_en[DMA_EN_BIT];
    assign rise       = en & ~en_prev_q;
    assign fall       = ~en & en_prev_q;
    assign n_words    = sd_counts[CNT_W-1:0];
    assign unused_cfg = ^{sd_addr[1:0], dest_addr[1:0], sd_counts[31:CNT_W], dma_en[31:1]};

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        data_d      = data_q;
        abort_d     = abort_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        aborted_d   = aborted_q;
        irq_d       = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (rise) begin
                    src_d     = {sd_addr[ADDR_W-1:2], 2'b00};
                    dst_d     = {dest_addr[ADDR_W-1:2], 2'b00};
                    rem_d     = n_words;
                    abort_d   = 1'b0;
                    aborted_d = 1'b0;
                    done_d    = n_words == '0;
                    irq_d     = n_words == '0;
                    busy_d    = n_words != '0;
                    state_d   = n_words == '0 ? DONE : RD;
                end else if (state_q == DONE && !en) begin
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            RD, WR: begin
                abort_d = abort_q | fall;
                // Raise a beat only after a full idle cycle, so req always drops between beats.
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = state_q == WR;
                    mem_addr_d  = state_q == WR ? dst_q : src_q;
                    mem_wdata_d = data_q;
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (state_q == RD) begin
                        data_d  = mem_rdata;
                        state_d = WR;
                    end else begin
                        src_d   = src_q + ADDR_W'(ADDR_STEP);
                        dst_d   = dst_q + ADDR_W'(ADDR_STEP);
                        rem_d   = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1) || abort_d) begin
                            state_d   = FIN;
                            busy_d    = 1'b0;
                            irq_d     = 1'b1;
                            done_d    = 1'b1;
                            aborted_d = abort_d;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            FIN:     state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            en_prev_q   <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            data_q      <= '0;
            abort_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_prev_q   <= en;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            data_q      <= data_d;
            abort_q     <= abort_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            irq_q       <= irq_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign irq       = irq_q;
endmodule
